// File: rtl/bip_ctrl_unit.sv
// rtl/bip_ctrl_unit.sv - BIP accumulator-machine control unit (FSM, PC, decode)
// Optional feature macro: BIP_BRANCH_EN enables JMP/BEQ/BNE decode.
module bip_ctrl_unit #(
    parameter int INSTR_W  = 16,
    parameter int OPCODE_W = 5,
    parameter int PC_W     = 11
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [INSTR_W-1:0]           i_instr,
    input  logic                         i_stall,
    input  logic                         i_acc_zero,
    output logic [PC_W-1:0]              o_PC,
    output logic [INSTR_W-OPCODE_W-1:0]  o_signal,
    output logic [1:0]                   o_selA,
    output logic                         o_selB,
    output logic                         o_WrAcc,
    output logic                         o_WrRam,
    output logic                         o_RdRam,
    output logic                         o_OP,
    output logic                         o_halted,
    output logic                         o_branch_taken
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;

    logic [OPCODE_W-1:0] opcode;
    logic [4:0]          op5;
    logic                op_ok;
    logic                taken;

    assign opcode   = i_instr[INSTR_W-1 -: OPCODE_W];
    assign op5      = opcode[4:0];
    // Any set opcode bit above the low five turns the word into a NOP.
    assign op_ok    = ((opcode >> 5) == '0);
    assign o_signal = i_instr[INSTR_W-OPCODE_W-1:0];

`ifdef BIP_BRANCH_EN
    always_comb begin
        taken = 1'b0;
        if (op_ok) begin
            case (op5)
                5'b01000: taken = 1'b1;
                5'b01001: taken = i_acc_zero;
                5'b01010: taken = ~i_acc_zero;
                default:  taken = 1'b0;
            endcase
        end
    end
`else
    logic unused_acc_zero;
    assign unused_acc_zero = i_acc_zero;
    assign taken = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        o_selA         = 2'b00;
        o_selB         = 1'b0;
        o_WrAcc        = 1'b0;
        o_WrRam        = 1'b0;
        o_RdRam        = 1'b0;
        o_OP           = 1'b0;
        o_branch_taken = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_RUN;
            S_RUN: begin
                // A stall suppresses everything, including HLT and branches.
                if (!i_stall) begin
                    pc_d = pc_q + PC_W'(1);
                    if (taken) begin
                        o_branch_taken = 1'b1;
                        pc_d           = o_signal[PC_W-1:0];
                    end else if (op_ok) begin
                        case (op5)
                            5'b00000: begin
                                state_d = S_HALT;
                                pc_d    = pc_q;
                            end
                            5'b00001: o_WrRam = 1'b1;
                            5'b00010: begin
                                o_RdRam = 1'b1;
                                o_WrAcc = 1'b1;
                            end
                            5'b00011: begin
                                o_selA  = 2'b01;
                                o_WrAcc = 1'b1;
                            end
                            5'b00100, 5'b00110: begin
                                o_RdRam = 1'b1;
                                o_selA  = 2'b10;
                                o_WrAcc = 1'b1;
                                o_OP    = op5[1];
                            end
                            5'b00101, 5'b00111: begin
                                o_selB  = 1'b1;
                                o_selA  = 2'b10;
                                o_WrAcc = 1'b1;
                                o_OP    = op5[1];
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign o_PC     = pc_q;
    assign o_halted = (state_q == S_HALT);

endmodule

// File: tb/tb_bip_ctrl_unit.sv
// tb/tb_bip_ctrl_unit.sv - directed plus randomized checks of bip_ctrl_unit against a reference model
module tb_bip_ctrl_unit;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic [15:0] i_instr = '0;
    logic        i_stall = 1'b0;
    logic        i_acc_zero = 1'b0;
    logic [10:0] o_PC;
    logic [10:0] o_signal;
    logic [1:0]  o_selA;
    logic        o_selB, o_WrAcc, o_WrRam, o_RdRam, o_OP, o_halted, o_branch_taken;

    int checks = 0;
    int errors = 0;

    // Reference state: mode 0 = idle, 1 = run, 2 = halted.
    int          m_mode = 0;
    logic [10:0] m_pc = '0;
    logic [6:0]  tbl [1:7];

`ifdef BIP_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    bip_ctrl_unit dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_instr(i_instr), .i_stall(i_stall),
        .i_acc_zero(i_acc_zero), .o_PC(o_PC), .o_signal(o_signal), .o_selA(o_selA),
        .o_selB(o_selB), .o_WrAcc(o_WrAcc), .o_WrRam(o_WrRam), .o_RdRam(o_RdRam),
        .o_OP(o_OP), .o_halted(o_halted), .o_branch_taken(o_branch_taken)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [4:0] opc, input logic [10:0] opnd);
        return {opc, opnd};
    endfunction

    task automatic step(input logic [15:0] instr, input logic stall, input logic az);
        logic [4:0]  opc;
        logic [6:0]  e;
        logic        e_br, tk;
        logic [10:0] nxt_pc;
        int          nxt_mode;
        i_instr = instr; i_stall = stall; i_acc_zero = az;
        @(negedge i_clk);
        opc = instr[15:11];
        e = '0; e_br = 1'b0; tk = 1'b0;
        nxt_pc = m_pc; nxt_mode = m_mode;
        if (m_mode == 0) begin
            nxt_mode = 1;
        end else if (m_mode == 1 && !stall) begin
            nxt_pc = m_pc + 11'd1;
            if (opc == 5'd0) begin
                nxt_mode = 2;
                nxt_pc = m_pc;
            end else if (opc <= 5'd7) begin
                e = tbl[int'(opc)];
            end else if (BR_EN && opc <= 5'd10) begin
                tk = (opc == 5'd8) || (opc == 5'd9 && az) || (opc == 5'd10 && !az);
                if (tk) begin
                    e_br = 1'b1;
                    nxt_pc = instr[10:0];
                end
            end
        end
        chk("pc", 16'(o_PC), 16'(m_pc));
        chk("signal", 16'(o_signal), 16'(instr[10:0]));
        chk("wrram", 16'(o_WrRam), 16'(e[6]));
        chk("rdram", 16'(o_RdRam), 16'(e[5]));
        chk("wracc", 16'(o_WrAcc), 16'(e[4]));
        chk("selA", 16'(o_selA), 16'(e[3:2]));
        chk("selB", 16'(o_selB), 16'(e[1]));
        chk("op", 16'(o_OP), 16'(e[0]));
        chk("halted", 16'(o_halted), 16'(m_mode == 2));
        chk("branch", 16'(o_branch_taken), 16'(e_br));
        @(posedge i_clk);
        #1;
        m_pc = nxt_pc;
        m_mode = nxt_mode;
    endtask

    // Asserts reset away from any clock edge and checks the asynchronous clear.
    task automatic do_reset();
        #2;
        i_reset = 1'b0;
        #1;
        chk("rst_pc", 16'(o_PC), 16'h0);
        chk("rst_halted", 16'(o_halted), 16'h0);
        chk("rst_en", 16'({o_WrAcc, o_WrRam, o_RdRam, o_branch_taken}), 16'h0);
        chk("rst_sel", 16'({o_selA, o_selB, o_OP}), 16'h0);
        m_mode = 0;
        m_pc = '0;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
    endtask

    initial begin
        logic [4:0] opc;
        int         guard;
        tbl[1] = 7'b1000000;
        tbl[2] = 7'b0110000;
        tbl[3] = 7'b0010100;
        tbl[4] = 7'b0111000;
        tbl[5] = 7'b0011010;
        tbl[6] = 7'b0111001;
        tbl[7] = 7'b0011011;

        do_reset();
        step(mk(5'd3, 11'h0), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(mk(5'd3, 11'h0), 1'b0, 1'b0);

        step(mk(5'd3, 11'h0), 1'b0, 1'b0);
        step(mk(5'd5, 11'd5), 1'b0, 1'b0);
        step(mk(5'd1, 11'd1), 1'b0, 1'b0);

        step(mk(5'd9, 11'h040), 1'b0, 1'b1);
        step(mk(5'd10, 11'h040), 1'b0, 1'b1);
        step(mk(5'd10, 11'h123), 1'b0, 1'b0);
        step(mk(5'd8, 11'h7F0), 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) step(mk(5'd1, 11'd2), 1'b1, 1'b0);
        step(mk(5'd1, 11'd2), 1'b0, 1'b0);
        step(mk(5'd0, 11'd0), 1'b1, 1'b0);
        step(mk(5'd4, 11'd3), 1'b0, 1'b0);

        do_reset();
        step(mk(5'd31, 11'h0), 1'b0, 1'b0);
        guard = 0;
        while (m_pc != 11'h7FF && guard < 3000) begin
            step(mk(5'd31, 11'($urandom)), 1'b0, 1'b0);
            guard++;
        end
        chk("reach_7ff", 16'(guard < 3000), 16'h1);
        step(mk(5'd31, 11'h0), 1'b0, 1'b0);
        step(mk(5'd31, 11'h0), 1'b0, 1'b0);

        do_reset();
        step(mk(5'd31, 11'h0), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(mk(5'd11, 11'h0), 1'b0, 1'b0);
        step(mk(5'd0, 11'h0), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(mk(5'd3, 11'h1), 1'b0, 1'b0);
        chk("halt_pc", 16'(m_pc), 16'h5);
        do_reset();

        step(mk(5'd3, 11'h0), 1'b0, 1'b0);
        for (int i = 0; i < 500; i++) begin
            opc = 5'($urandom_range(0, 31));
            if (opc == 5'd0 && $urandom_range(0, 7) != 0) opc = 5'd3;
            step(mk(opc, 11'($urandom)), ($urandom_range(0, 3) == 0), 1'($urandom));
            if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0)
                do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
